cnt_seq_checker: RTL and testbench

- Receive-side monitor for the 4-bit up/down counter with selectable step 1/2. The counter is the "transmitter"; this block is the "receiver".
- Samples the counter value every clock, together with the mode inputs that drove it, and predicts the next value.
- Locks after a run of correct transitions and reports sequence errors with a saturating error count.
- Sits beside the counter in the lab top level and in the counter testbench as a self-checking observer.

---
 rtl/cnt_seq_pkg.sv | 29 ++
 rtl/cnt_predict.sv | 17 +
 rtl/cnt_seq_checker.sv | 159 +++++++++++++++
 tb/tb_cnt_seq_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and next-value rule for the 4-bit up/down counter with
// selectable step 1/2. Used by the sequence checker and future counter models.
package cnt_seq_pkg;

    typedef enum logic [1:0] {UNSYNC, TRACK, LOCKED} chk_state_t;

    typedef logic [3:0] cnt_val_t;

    // Step-2 walks a full 16-state ring: 0,2,..,14,1,3,..,15,0 (and reverse).
    function automatic cnt_val_t cnt_next(cnt_val_t v, logic en, logic down, logic step);
        cnt_val_t r;
        r = v;
        if (en) begin
            if (!step) begin
                r = down ? v - 4'd1 : v + 4'd1;
            end else if (!down) begin
                if (v <= 4'd13)      r = v + 4'd2;
                else if (v == 4'd14) r = 4'd1;
                else                 r = 4'd0;
            end else begin
                if (v >= 4'd2)       r = v - 4'd2;
                else if (v == 4'd1)  r = 4'd14;
                else                 r = 4'd15;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_predict.sv
// Combinational next-value predictor for the up/down step-1/2 counter.
module cnt_predict
    import cnt_seq_pkg::*;
(
    input  logic [3:0] val,
    input  logic       en,
    input  logic       down,
    input  logic       step,
    output logic [3:0] nxt
);

    // Pure wrapper around the shared counter rule
    always_comb begin
        nxt = cnt_next(val, en, down, step);
    end

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side sequence checker for the 4-bit up/down counter.
// Predicts each sample from the previous sample and mode, locks after a run
// of correct transitions, and flags/counts mismatches while locked.
// Optional macro CHK_CAPTURE_EN adds first-error capture outputs.
module cnt_seq_checker
    import cnt_seq_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
)
(
    input  logic             clk,
    input  logic             nrst,
    input  logic [3:0]       val,
    input  logic             en,
    input  logic             down,
    input  logic             step,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       exp_val
`ifdef CHK_CAPTURE_EN
    ,
    output logic [3:0]       cap_exp,
    output logic [3:0]       cap_got,
    output logic             cap_vld
`endif
);

    chk_state_t       state_q, state_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    cnt_val_t         exp_val_q, exp_val_d;
    cnt_val_t         nxt_val;
    logic             mismatch;

    // The prediction is formed one cycle early from the live sample and mode
    // and registered, which is the same value as predicting from registered
    // prev/mode, so no separate prev/mode flops are kept.
    cnt_predict u_predict (
        .val  (val),
        .en   (en),
        .down (down),
        .step (step),
        .nxt  (nxt_val)
    );

    // Sync FSM, lock counter, error pulse and saturating error count
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        exp_val_d  = nxt_val;
        mismatch   = (val != exp_val_q);

        unique case (state_q)
            UNSYNC: begin
                state_d    = TRACK;
                good_cnt_d = '0;
            end
            TRACK: begin
                if (mismatch) begin
                    good_cnt_d = '0;
                end else if (good_cnt_q == 4'(LOCK_CNT)) begin
                    state_d = LOCKED;
                end else begin
                    good_cnt_d = good_cnt_q + 4'd1;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    err_d      = 1'b1;
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = UNSYNC;
                good_cnt_d = '0;
            end
        endcase

        if (err_clr) begin
            err_cnt_d = err_d ? ERR_W'(1) : '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= UNSYNC;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            exp_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            exp_val_q  <= exp_val_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign exp_val = exp_val_q;

`ifdef CHK_CAPTURE_EN
    logic [3:0] cap_exp_q, cap_exp_d;
    logic [3:0] cap_got_q, cap_got_d;
    logic       cap_vld_q, cap_vld_d;

    // Hold the first error since reset/clear; clear wins over a same-cycle error
    always_comb begin
        cap_exp_d = cap_exp_q;
        cap_got_d = cap_got_q;
        cap_vld_d = cap_vld_q;
        if (err_clr) begin
            cap_exp_d = '0;
            cap_got_d = '0;
            cap_vld_d = 1'b0;
        end else if (err_d && !cap_vld_q) begin
            cap_exp_d = exp_val_q;
            cap_got_d = val;
            cap_vld_d = 1'b1;
        end
    end

    // Capture registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_exp_q <= '0;
            cap_got_q <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_exp_q <= cap_exp_d;
            cap_got_q <= cap_got_d;
            cap_vld_q <= cap_vld_d;
        end
    end

    assign cap_exp = cap_exp_q;
    assign cap_got = cap_got_q;
    assign cap_vld = cap_vld_q;
`endif

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Self-checking bench for cnt_seq_checker: directed scenarios plus random
// counter traffic with injected errors, against a behavioural model.
`timescale 1ns/1ps
module tb_cnt_seq_checker;

    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             nrst;
    logic [3:0]       val;
    logic             en, down, step, err_clr;
    logic             locked, err;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       exp_val;
`ifdef CHK_CAPTURE_EN
    logic [3:0]       cap_exp, cap_got;
    logic             cap_vld;
`endif

    always #5 clk = ~clk;

    cnt_seq_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .val     (val),
        .en      (en),
        .down    (down),
        .step    (step),
        .err_clr (err_clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt),
        .exp_val (exp_val)
`ifdef CHK_CAPTURE_EN
        ,
        .cap_exp (cap_exp),
        .cap_got (cap_got),
        .cap_vld (cap_vld)
`endif
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Reference counter rule: step-1 is plain mod-16 arithmetic, step-2 moves
    // one position around the ring 0,2,..,14,1,3,..,15.
    function automatic logic [3:0] ref_next(logic [3:0] v, logic e, logic d, logic s);
        int p;
        if (!e) return v;
        if (!s) return d ? 4'((int'(v) + 15) % 16) : 4'((int'(v) + 1) % 16);
        p = v[0] ? 8 + int'(v) / 2 : int'(v) / 2;
        p = d ? (p + 15) % 16 : (p + 1) % 16;
        return (p < 8) ? 4'(2 * p) : 4'(2 * (p - 8) + 1);
    endfunction

    // Behavioural model
    bit          m_seen;
    bit          m_locked;
    int unsigned m_streak;
    logic [3:0]  m_exp;
    bit          m_err;
    int unsigned m_cnt;
    logic [3:0]  m_cap_exp, m_cap_got;
    bit          m_cap_vld;
    logic [3:0]  c;

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_streak = 0; m_exp = '0;
        m_err = 0; m_cnt = 0; m_cap_exp = '0; m_cap_got = '0; m_cap_vld = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic e, d, s, clr);
        bit new_err;
        new_err = 0;
        if (!m_seen) begin
            m_seen = 1;
            m_streak = 0;
        end else if (!m_locked) begin
            m_streak = (v == m_exp) ? m_streak + 1 : 0;
            if (m_streak == LOCK_CNT + 1) m_locked = 1;
        end else if (v != m_exp) begin
            new_err = 1;
            m_locked = 0;
            m_streak = 0;
        end
        if (clr) begin
            m_cap_exp = '0; m_cap_got = '0; m_cap_vld = 0;
        end else if (new_err && !m_cap_vld) begin
            m_cap_exp = m_exp; m_cap_got = v; m_cap_vld = 1;
        end
        if (clr) m_cnt = new_err ? 1 : 0;
        else if (new_err && m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
        m_err = new_err;
        m_exp = ref_next(v, e, d, s);
    endtask

    task automatic cyc(input logic [3:0] v, input logic e, d, s, clr);
        val = v; en = e; down = d; step = s; err_clr = clr;
        @(posedge clk);
        model_step(v, e, d, s, clr);
        #1;
        chk("locked", locked, m_locked);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        chk("exp_val", exp_val, m_exp);
`ifdef CHK_CAPTURE_EN
        chk("cap_exp", cap_exp, m_cap_exp);
        chk("cap_got", cap_got, m_cap_got);
        chk("cap_vld", cap_vld, m_cap_vld);
`endif
    endtask

    task automatic legal(input logic e, d, s, clr);
        cyc(c, e, d, s, clr);
        c = ref_next(c, e, d, s);
    endtask

    task automatic inject(input logic e, d, s, clr);
        logic [3:0] bad;
        bad = c ^ 4'($urandom_range(1, 15));
        cyc(bad, e, d, s, clr);
        c = ref_next(bad, e, d, s);
    endtask

    task automatic relock();
        repeat (LOCK_CNT + 1) legal(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0; val = '0; en = 1'b0; down = 1'b0; step = 1'b0; err_clr = 1'b0;
        c = '0;
        model_reset();
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_exp_val", exp_val, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Lock from reset: counting up by 1 from 0, locked on the 6th edge
        for (int k = 1; k <= 8; k++) begin
            legal(1'b1, 1'b0, 1'b0, 1'b0);
            chk("lock_edge", locked, (k >= 6) ? 1 : 0);
            chk("lock_no_err", err, 0);
        end

        // Step-2 up through 12,14,1,3
        repeat (6) begin
            legal(1'b1, 1'b0, 1'b1, 1'b0);
            chk("up2_no_err", err, 0);
            chk("up2_locked", locked, 1);
        end

        // Step-2 down 1 -> 14 is legal
        for (int i = 0; i < 16 && c != 4'd1; i++) legal(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) begin
            legal(1'b1, 1'b1, 1'b1, 1'b0);
            chk("dn2_no_err", err, 0);
        end
        // 1 followed by 15 is an error
        for (int i = 0; i < 16 && c != 4'd1; i++) legal(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(4'd15, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("dn2_err", err, 1);
        chk("dn2_err_cnt", err_cnt, 1);
        chk("dn2_unlocked", locked, 0);
        c = ref_next(4'd15, 1'b1, 1'b1, 1'b1);
        legal(1'b1, 1'b1, 1'b1, 1'b0);
        chk("dn2_err_pulse", err, 0);

        // Hold at 7 with en=0, then direction toggling every cycle
        relock();
        chk("relock", locked, 1);
        for (int i = 0; i < 16 && c != 4'd7; i++) legal(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            legal(1'b0, 1'b0, 1'b0, 1'b0);
            chk("hold_locked", locked, 1);
            chk("hold_no_err", err, 0);
            chk("hold_val", exp_val, 7);
        end
        for (int i = 0; i < 10; i++) begin
            legal(1'b1, 1'(i % 2), 1'b0, 1'b0);
            chk("toggle_no_err", err, 0);
        end

        // Error counter saturation and clearing
        for (int i = 0; i < 300; i++) begin
            inject(1'b1, 1'b0, 1'b0, 1'b0);
            relock();
        end
        chk("sat_err_cnt", err_cnt, ERR_MAX);
        legal(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_alone", err_cnt, 0);
        inject(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_with_err", err_cnt, 1);
        relock();

        // Random traffic with occasional errors and clears
        for (int i = 0; i < 2000; i++) begin
            int unsigned r;
            logic e, d, s, clr;
            r   = $urandom_range(0, 99);
            e   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            clr = (r < 3);
            if (r >= 95) inject(e, d, s, clr);
            else         legal(e, d, s, clr);
        end

        // Asynchronous reset in the middle of LOCKED
        inject(1'b1, 1'b0, 1'b0, 1'b0);
        relock();
        chk("pre_rst_locked", locked, 1);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err", err, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_exp_val", exp_val, 0);
`ifdef CHK_CAPTURE_EN
        chk("arst_cap_vld", cap_vld, 0);
        chk("arst_cap_exp", cap_exp, 0);
        chk("arst_cap_got", cap_got, 0);
`endif
        model_reset();
        c = '0;
        #1;
        nrst = 1'b1;
        repeat (6) legal(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_locked", locked, 1);

`ifdef CHK_CAPTURE_EN
        // Locked at 5 counting up by 1: inject 9 where 6 is expected
        cyc(4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cap1_exp", cap_exp, 6);
        chk("cap1_got", cap_got, 9);
        chk("cap1_vld", cap_vld, 1);
        c = ref_next(4'd9, 1'b1, 1'b0, 1'b0);
        relock();
        inject(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cap2_err", err, 1);
        chk("cap2_exp", cap_exp, 6);
        chk("cap2_got", cap_got, 9);
        legal(1'b1, 1'b0, 1'b0, 1'b1);
        chk("cap_clr_vld", cap_vld, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
